// File: rtl/bldc_commutator_if.sv
// bldc_commutator_if
//   Groups the commutator's control inputs and bridge/status outputs.
//   master: the side that drives hall/fault/enable/dir/pwm/clear and
//           observes gates and status (controller or bench).
//   slave : the commutator itself.
//   Signals: hall[2:0], fault_n, enable, dir, pwm_in, clear_fault (to slave);
//            INHA..INLC, sector[2:0], hall_error, fault_latched, stalled (from slave).
interface bldc_commutator_if;
  logic [2:0] hall;
  logic       fault_n;
  logic       enable;
  logic       dir;
  logic       pwm_in;
  logic       clear_fault;
  logic       INHA, INLA, INHB, INLB, INHC, INLC;
  logic [2:0] sector;
  logic       hall_error;
  logic       fault_latched;
  logic       stalled;

  modport master (
    output hall, fault_n, enable, dir, pwm_in, clear_fault,
    input  INHA, INLA, INHB, INLB, INHC, INLC,
    input  sector, hall_error, fault_latched, stalled
  );

  modport slave (
    input  hall, fault_n, enable, dir, pwm_in, clear_fault,
    output INHA, INLA, INHB, INLB, INHC, INLC,
    output sector, hall_error, fault_latched, stalled
  );
endinterface

// File: rtl/bldc_commutator.sv
// bldc_commutator
//   Hall-driven six-step commutation for a three-phase gate driver.
//   Synchronizes and filters the hall code, maps it to a sector, picks the
//   high/low switch pair for the sector and direction, and blanks all gates
//   for DEADTIME cycles on every pattern change. Latches driver faults and
//   flags a rotor that sits in one sector too long.
//   Ports:
//     CLK      system clock
//     reset_n  synchronous active-low reset
//     bus      bldc_commutator_if.slave (hall/fault/enable/dir/pwm/clear in,
//              gate pins and sector/hall_error/fault_latched/stalled out)
module bldc_commutator #(
  parameter int unsigned DEADTIME      = 64,
  parameter int unsigned HALL_FILTER   = 4,
  parameter int unsigned STALL_TIMEOUT = 16_000_000
) (
  input  logic             CLK,
  input  logic             reset_n,
  bldc_commutator_if.slave bus
);

  typedef enum logic [1:0] {S_DISABLED, S_DEADTIME, S_DRIVE, S_FAULT} state_e;

  localparam logic [8:0]  HF_LIM   = 9'(HALL_FILTER);
  localparam logic [15:0] DT_LOAD  = 16'(DEADTIME - 1);
  localparam logic [31:0] ST_LIM   = 32'(STALL_TIMEOUT);
  localparam logic [2:0]  SEC_NONE = 3'd7;

  // hall code -> sector A..F (0..5); 000/111 are not valid codes
  function automatic logic [2:0] hall2sec(input logic [2:0] h);
    case (h)
      3'b101:  return 3'd0;
      3'b100:  return 3'd1;
      3'b110:  return 3'd2;
      3'b010:  return 3'd3;
      3'b011:  return 3'd4;
      3'b001:  return 3'd5;
      default: return SEC_NONE;
    endcase
  endfunction

  // {gh[C:A], gl[C:A]} for a sector. The reverse table is the forward
  // table rotated by three sectors, so only one table is stored.
  function automatic logic [5:0] drive_pat(input logic [2:0] sec, input logic fwd);
    logic [2:0] s;
    s = sec;
    if (!fwd && sec <= 3'd5) s = (sec >= 3'd3) ? sec - 3'd3 : sec + 3'd3;
    case (s)
      3'd0:    return {3'b100, 3'b010};  // HC, LB
      3'd1:    return {3'b001, 3'b010};  // HA, LB
      3'd2:    return {3'b001, 3'b100};  // HA, LC
      3'd3:    return {3'b010, 3'b100};  // HB, LC
      3'd4:    return {3'b010, 3'b001};  // HB, LA
      3'd5:    return {3'b100, 3'b001};  // HC, LA
      default: return 6'b0;
    endcase
  endfunction

  logic [2:0]  hall_s1_q, hall_s1_d, hall_s2_q, hall_s2_d;
  logic        flt_s1_q, flt_s1_d, flt_s2_q, flt_s2_d;
  logic [2:0]  cand_q, cand_d;
  logic [7:0]  filt_cnt_q, filt_cnt_d;
  logic [2:0]  sector_q, sector_d, sec_prev_q, sec_prev_d;
  logic        hall_err_q, hall_err_d;
  logic        dir_q, dir_d, dir_prev_q, dir_prev_d;
  state_e      state_q, state_d;
  logic [15:0] dt_cnt_q, dt_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stalled_q, stalled_d;
  logic        flt_lat_q, flt_lat_d;
  logic [2:0]  gh_q, gh_d, gl_q, gl_d;

  logic [8:0]  run;
  logic        accept;
  logic        pat_chg;
  logic        sec_ok;

  // Front end: synchronizers, hall filter, sector decode, change detect
  always_comb begin
    hall_s1_d  = bus.hall;
    hall_s2_d  = hall_s1_q;
    flt_s1_d   = bus.fault_n;
    flt_s2_d   = flt_s1_q;
    dir_d      = bus.dir;
    sec_prev_d = sector_q;
    dir_prev_d = dir_q;

    // run = length of the current streak of identical samples, this one included
    run        = (hall_s2_q == cand_q) ? {1'b0, filt_cnt_q} + 9'd1 : 9'd1;
    accept     = (run >= HF_LIM);
    cand_d     = hall_s2_q;
    filt_cnt_d = accept ? HF_LIM[7:0] : run[7:0];

    sector_d   = sector_q;
    hall_err_d = hall_err_q;
    if (accept) begin
      sector_d   = hall2sec(hall_s2_q);
      hall_err_d = (hall2sec(hall_s2_q) == SEC_NONE);
    end

    // sector/dir registers moved on the previous edge
    pat_chg = (sector_q != sec_prev_q) || (dir_q != dir_prev_q);
    sec_ok  = (sector_q != SEC_NONE);
  end

  // Commutation FSM, gate pattern, stall detection
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    case (state_q)
      S_DISABLED: if (bus.enable && sec_ok) begin
        state_d  = S_DEADTIME;
        dt_cnt_d = DT_LOAD;
      end
      S_DEADTIME: begin
        if (pat_chg)               dt_cnt_d = DT_LOAD;
        else if (dt_cnt_q == '0)   state_d  = S_DRIVE;
        else                       dt_cnt_d = dt_cnt_q - 16'd1;
      end
      S_DRIVE: if (pat_chg) begin
        state_d  = S_DEADTIME;
        dt_cnt_d = DT_LOAD;
      end
      S_FAULT: if (bus.clear_fault && flt_s2_q) state_d = S_DISABLED;
      default: state_d = S_DISABLED;
    endcase
    // Overrides, lowest priority first so the last one wins
    if (state_q != S_FAULT && (!bus.enable || hall_err_q)) state_d = S_DISABLED;
    if (!flt_s2_q) state_d = S_FAULT;

    gh_d = '0;
    gl_d = '0;
    if (state_d == S_DRIVE) {gh_d, gl_d} = drive_pat(sector_q, dir_q);

    // Only consecutive DRIVE cycles count; any exit (including a sector
    // change, which always leaves DRIVE) clears it
    stall_cnt_d = '0;
    if (state_q == S_DRIVE && state_d == S_DRIVE)
      stall_cnt_d = (stall_cnt_q >= ST_LIM) ? stall_cnt_q : stall_cnt_q + 32'd1;
    stalled_d = (stall_cnt_d >= ST_LIM);

    flt_lat_d = (state_d == S_FAULT);
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      hall_s1_q   <= '0;
      hall_s2_q   <= '0;
      // fault synchronizer clears to the no-fault level so reset alone
      // never latches a fault
      flt_s1_q    <= 1'b1;
      flt_s2_q    <= 1'b1;
      cand_q      <= '0;
      filt_cnt_q  <= '0;
      sector_q    <= SEC_NONE;
      sec_prev_q  <= SEC_NONE;
      hall_err_q  <= 1'b0;
      dir_q       <= 1'b0;
      dir_prev_q  <= 1'b0;
      state_q     <= S_DISABLED;
      dt_cnt_q    <= '0;
      stall_cnt_q <= '0;
      stalled_q   <= 1'b0;
      flt_lat_q   <= 1'b0;
      gh_q        <= '0;
      gl_q        <= '0;
    end else begin
      hall_s1_q   <= hall_s1_d;
      hall_s2_q   <= hall_s2_d;
      flt_s1_q    <= flt_s1_d;
      flt_s2_q    <= flt_s2_d;
      cand_q      <= cand_d;
      filt_cnt_q  <= filt_cnt_d;
      sector_q    <= sector_d;
      sec_prev_q  <= sec_prev_d;
      hall_err_q  <= hall_err_d;
      dir_q       <= dir_d;
      dir_prev_q  <= dir_prev_d;
      state_q     <= state_d;
      dt_cnt_q    <= dt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      stalled_q   <= stalled_d;
      flt_lat_q   <= flt_lat_d;
      gh_q        <= gh_d;
      gl_q        <= gl_d;
    end
  end

  // PWM chops the high sides only; low sides stay solidly on
  assign bus.INHA = gh_q[0] & bus.pwm_in;
  assign bus.INHB = gh_q[1] & bus.pwm_in;
  assign bus.INHC = gh_q[2] & bus.pwm_in;
  assign bus.INLA = gl_q[0];
  assign bus.INLB = gl_q[1];
  assign bus.INLC = gl_q[2];

  assign bus.sector        = sector_q;
  assign bus.hall_error    = hall_err_q;
  assign bus.fault_latched = flt_lat_q;
  assign bus.stalled       = stalled_q;

endmodule

// File: tb/tb_bldc_commutator.sv
// tb_bldc_commutator
//   Scoreboard bench: each stimulus step pushes the outputs it expects,
//   tagged with the cycle they are due; a negedge monitor pops and compares.
//   Observed word: {INHA,INLA,INHB,INLB,INHC,INLC, sector[2:0], hall_error,
//   fault_latched, stalled}.
module tb_bldc_commutator;
  localparam int DT = 64;
  localparam int HF = 4;
  localparam int ST = 100;

  localparam logic [11:0] M_GATES = 12'hFC0;
  localparam logic [11:0] M_SEC   = 12'h038;
  localparam logic [11:0] M_HERR  = 12'h004;
  localparam logic [11:0] M_FLT   = 12'h002;
  localparam logic [11:0] M_STALL = 12'h001;
  localparam logic [11:0] M_ALL   = 12'hFFF;

  logic CLK = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  bldc_commutator_if bus();

  bldc_commutator #(.DEADTIME(DT), .HALL_FILTER(HF), .STALL_TIMEOUT(ST)) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    int          due;
    logic [11:0] mask;
    logic [11:0] val;
  } exp_t;
  exp_t sb[$];

  // high/low phase index (0=A,1=B,2=C) per sector A..F
  int fwd_h [6] = '{2, 0, 0, 1, 1, 2};
  int fwd_l [6] = '{1, 1, 2, 2, 0, 0};
  int rev_h [6] = '{1, 1, 2, 2, 0, 0};
  int rev_l [6] = '{2, 0, 0, 1, 1, 2};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [5:0] pins(input int h, input int l);
    logic [5:0] r;
    r = '0;
    r[5 - 2*h] = 1'b1;
    r[4 - 2*l] = 1'b1;
    return r;
  endfunction

  function automatic logic [11:0] sec(input logic [2:0] s);
    return {6'b0, s, 3'b0};
  endfunction

  task automatic push(input string tag, input int due, input logic [11:0] mask,
                      input logic [11:0] val);
    exp_t e;
    e.tag = tag; e.due = due; e.mask = mask; e.val = val;
    sb.push_back(e);
  endtask

  // Pattern update at edge e: gates dark for DT cycles, then pattern p
  task automatic exp_switch(input string tag, input int e, input logic [5:0] p);
    for (int k = 1; k <= DT; k++) push({tag, "_dt"}, e + k, M_GATES, 12'h000);
    push(tag, e + 1 + DT, M_GATES, {p, 6'b0});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    do begin step(1); n++; end while (sb.size() != 0 && n < budget);
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Monitor: shoot-through rule every cycle, then due scoreboard entries
  always @(negedge CLK) begin
    logic [11:0] obs;
    logic [2:0]  h, l;
    logic        bad;
    obs = {bus.INHA, bus.INLA, bus.INHB, bus.INLB, bus.INHC, bus.INLC,
           bus.sector, bus.hall_error, bus.fault_latched, bus.stalled};
    h   = {bus.INHA, bus.INHB, bus.INHC};
    l   = {bus.INLA, bus.INLB, bus.INLC};
    bad = (|(h & l)) || ($countones(h) > 1) || ($countones(l) > 1);
    chk("shoot_through", bad, 1'b0);
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, obs & sb[i].mask, sb[i].val & sb[i].mask);
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        chk({sb[i].tag, "_missed"}, 1, 0);
        sb.delete(i);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, d;
    bus.hall = 3'b100; bus.fault_n = 1'b1; bus.enable = 1'b1;
    bus.dir = 1'b1; bus.pwm_in = 1'b1; bus.clear_fault = 1'b0;
    reset_n = 1'b0;
    step(3);
    push("reset_state", cyc, M_ALL, sec(3'd7));
    drain(5);

    // Power-up at sector B, forward
    reset_n = 1'b1; t = cyc;
    push("b_sec_early", t + 5, M_SEC, sec(3'd7));
    push("b_sec", t + 6, M_SEC | M_HERR, sec(3'd1));
    exp_switch("b_drive", t + 6, pins(fwd_h[1], fwd_l[1]));
    drain(200);

    // B -> C
    bus.hall = 3'b110; t = cyc;
    push("c_sec_early", t + 5, M_SEC, sec(3'd1));
    push("c_sec", t + 6, M_SEC, sec(3'd2));
    push("c_old_pat", t + 6, M_GATES, {pins(fwd_h[1], fwd_l[1]), 6'b0});
    exp_switch("c_drive", t + 6, pins(fwd_h[2], fwd_l[2]));
    drain(200);

    // PWM only gates the high side
    step(3);
    bus.pwm_in = 1'b0;
    push("pwm_lo", cyc, M_GATES, {pins(fwd_h[2], fwd_l[2]) & 6'b010101, 6'b0});
    step(2);
    bus.pwm_in = 1'b1;
    push("pwm_hi", cyc, M_GATES, {pins(fwd_h[2], fwd_l[2]), 6'b0});
    drain(10);

    // 3-cycle glitch must be filtered: no sector change, no blanking
    bus.hall = 3'b010; t = cyc;
    for (int k = 1; k <= 24; k++)
      push("glitch", t + k, M_GATES | M_SEC, {pins(fwd_h[2], fwd_l[2]), 3'd2, 3'b0});
    step(3);
    bus.hall = 3'b110;
    drain(40);

    // One-cycle fault pulse
    bus.fault_n = 1'b0; t = cyc;
    push("flt_pre", t + 2, M_GATES | M_FLT, {pins(fwd_h[2], fwd_l[2]), 6'b0});
    push("flt_off", t + 3, M_GATES | M_FLT, 12'h002);
    step(1);
    bus.fault_n = 1'b1;
    drain(20);

    // clear while fault persists is ignored
    bus.fault_n = 1'b0;
    step(4);
    bus.clear_fault = 1'b1; t = cyc;
    push("clr_ignored1", t + 1, M_GATES | M_FLT, 12'h002);
    push("clr_ignored3", t + 3, M_GATES | M_FLT, 12'h002);
    step(1);
    bus.clear_fault = 1'b0;
    drain(10);

    // fault gone, clear releases, then dead-time and drive
    bus.fault_n = 1'b1;
    step(4);
    bus.clear_fault = 1'b1; t = cyc;
    push("clr_hold", t, M_FLT, 12'h002);
    push("clr_done", t + 1, M_FLT, 12'h000);
    exp_switch("clr_drive", t + 1, pins(fwd_h[2], fwd_l[2]));
    step(1);
    bus.clear_fault = 1'b0;
    drain(200);

    // Invalid hall code
    bus.hall = 3'b111; t = cyc;
    push("herr_set", t + 6, M_SEC | M_HERR, {6'b0, 3'd7, 3'b100});
    push("herr_pat", t + 6, M_GATES, {pins(fwd_h[2], fwd_l[2]), 6'b0});
    push("herr_off7", t + 7, M_GATES, 12'h000);
    push("herr_off8", t + 8, M_GATES, 12'h000);
    drain(20);

    // Back to valid sector A
    bus.hall = 3'b101; t = cyc;
    push("a_sec", t + 6, M_SEC | M_HERR, sec(3'd0));
    exp_switch("a_drive", t + 6, pins(fwd_h[0], fwd_l[0]));
    drain(200);

    // Direction flip, same sector
    bus.dir = 1'b0; t = cyc;
    push("rev_old_pat", t + 1, M_GATES, {pins(fwd_h[0], fwd_l[0]), 6'b0});
    exp_switch("rev_drive", t + 1, pins(rev_h[0], rev_l[0]));
    drain(200);

    // Stall: forward, sector C held
    bus.dir = 1'b1; bus.hall = 3'b110; t = cyc;
    exp_switch("stall_drive", t + 6, pins(fwd_h[2], fwd_l[2]));
    d = t + 7 + DT;
    push("stall_pre", d + ST - 1, M_STALL | M_SEC, sec(3'd2));
    push("stall_set", d + ST, M_STALL | M_SEC, sec(3'd2) | 12'h001);
    drain(300);
    step(5);
    bus.hall = 3'b010; t = cyc;
    push("stall_hold", t + 6, M_STALL, 12'h001);
    push("stall_clr", t + 7, M_STALL, 12'h000);
    drain(20);

    // Reset pulses at arbitrary points
    for (int r = 0; r < 3; r++) begin
      step($urandom_range(5, 90));
      reset_n = 1'b0; t = cyc;
      push("rr_reset", t + 1, M_ALL, sec(3'd7));
      step(1);
      reset_n = 1'b1;
      push("rr_sec", t + 7, M_SEC | M_HERR, sec(3'd3));
      exp_switch("rr_drive", t + 7, pins(fwd_h[3], fwd_l[3]));
      drain(200);
    end

    step(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bldc_commutator.md
# bldc_commutator

Hall-sensor-driven six-step commutation controller for the three-phase gate driver. Filters the hall inputs, selects the active high/low switch pair from sector and direction, and inserts a dead-time blanking interval on every switching-pattern change. Latches driver faults and flags stalled rotors. Sits between the PWM generator output, the direction/enable logic and the INHx/INLx pins; it is the block that sequences access to the bridge.

## Interface
- DEADTIME, 64: all-gates-off clock cycles inserted on every pattern change, 1..65535
- HALL_FILTER, 4: consecutive identical synchronized hall samples required before a sector is accepted, 1..255
- STALL_TIMEOUT, 16_000_000: clock cycles in DRIVE without a sector change before `stalled` asserts (32-bit counter)
- CLK  in  1  system clock (16 MHz)
- reset_n  in  1  synchronous, active-low reset
- hall  in  3  {hall1,hall2,hall3}, asynchronous
- fault_n  in  1  driver fault, active-low, asynchronous
- enable  in  1  bridge enable
- dir  in  1  1 = forward table, 0 = reverse table
- pwm_in  in  1  PWM from the PWM generator; gates high sides only
- clear_fault  in  1  single-cycle pulse; releases a latched fault
- INHA, INLA, INHB, INLB, INHC, INLC  out  1 each  gate commands
- sector  out  3  accepted sector 0..5 (A..F); 7 = none/invalid
- hall_error  out  1  accepted hall code is 000 or 111
- fault_latched  out  1  fault latched
- stalled  out  1  stall flag

## Operation
- hall and fault_n each pass through a 2-FF synchronizer.
- Hall filter: candidate code accepted when equal for HALL_FILTER consecutive cycles; any difference restarts the count.
- Code map: 101→A(0), 100→B(1), 110→C(2), 010→D(3), 011→E(4), 001→F(5); 000/111 → sector 7, hall_error=1.
- Forward (dir=1) high,low pairs: A: HC,LB; B: HA,LB; C: HA,LC; D: HB,LC; E: HB,LA; F: HC,LA.
- Reverse (dir=0): A: HB,LC; B: HB,LA; C: HC,LA; D: HC,LB; E: HA,LB; F: HA,LC.
- Registered gate bits gh[A..C], gl[A..C]; INHx = ghx & pwm_in (combinational AND only); INLx = glx.
- FSM states: DISABLED, DEADTIME, DRIVE, FAULT. Priority per cycle: FAULT entry > enable=0 > hall_error > pattern change.
  - DISABLED: gates 0. Leaves to DEADTIME when enable=1 and sector valid.
  - DEADTIME: gates 0, down-counter loaded DEADTIME-1; at 0 → DRIVE. Any sector or dir change restarts the counter.
  - DRIVE: gates = table(sector, dir). A sector or dir change → DEADTIME.
  - Any state: synchronized fault_n=0 → FAULT; enable=0 or hall_error → DISABLED (except from FAULT).
  - FAULT: gates 0, fault_latched=1. clear_fault=1 with synchronized fault_n=1 → DISABLED, fault_latched=0. clear_fault ignored while fault persists.
- Stall counter: runs only in DRIVE; cleared on a sector change or on leaving DRIVE; saturates. `stalled`=1 when count reaches STALL_TIMEOUT, cleared with the counter. Flag only; drive continues.
- Never assert gh and gl of the same phase; never assert more than one gh or more than one gl.

## Timing
- Reset (reset_n=0 at a CLK edge): state DISABLED, all gate regs 0 (all six outputs 0 regardless of pwm_in), sector=7, hall_error=0, fault_latched=0, stalled=0, filter/dead-time/stall counters 0, synchronizers cleared. Reset mid-DRIVE turns gates off at that edge.
- Hall latency: pin change → sector update after 2+HALL_FILTER cycles.
- After a sector/dir update at edge E, gate regs are 0 from edge E+1 for exactly DEADTIME cycles; the new pattern appears at edge E+1+DEADTIME.
- Fault latency: fault_n fall → gates 0 within 3 edges (2 sync + 1 register).
- enable fall → gates 0 at the next edge; enable rise with a valid sector → DEADTIME, then drive.
- sector, hall_error, fault_latched and stalled are registered.

## Test plan
- Reset, enable=1, dir=1, hall=100 held, pwm_in=1 → sector=1 after 6 cycles; gates 0 for 64 cycles; then INHA=1, INLB=1, all others 0.
- In DRIVE at B, hall→110 → sector=2 after 6 cycles; all six outputs 0 for exactly 64 cycles; then INHA=1, INLC=1. Toggle pwm_in → INHA follows, INLC stays 1.
- Hall glitch 100→110 for 3 cycles then back (HALL_FILTER=4) → sector stays 1, no dead-time interval.
- fault_n=0 for 1 cycle during DRIVE → all outputs 0 within 3 cycles, fault_latched=1; clear_fault while fault_n=0 → no effect; clear_fault after fault_n=1 → fault_latched=0, DISABLED → 64-cycle dead-time → DRIVE.
- hall=111 → hall_error=1, sector=7, outputs 0; hall=101 → hall_error=0, dead-time, then INHC=1, INLB=1 (dir=1); flip dir=0 → dead-time, then INHB=1, INLC=1.
- STALL_TIMEOUT=100, hold sector C in DRIVE → stalled=1 after 100 DRIVE cycles; a sector change clears it the next cycle. Assert a random reset_n pulse at any state → reset values hold; check the shoot-through rule on every cycle.
